axil_ram_arb: RTL and testbench
===============================

// Module: axil_ram_arb
// PURPOSE
//  Parametrised AXI4-Lite RAM, successor to the single-mode AXI-Lite RAM slave.
//  - Storage is one single-port array, so at most one read or one write per cycle.
//  - Adds a configurable read/write arbitration mode (round-robin or write-priority).
//  - Adds a non-power-of-two depth with a base address; accesses outside the window get SLVERR.
//  - Sits as a leaf slave behind the AXI-Lite interconnect; it is the target of the slave formal harness.
// PARAMETERS
//  DATA_WIDTH       32    data bus width in bits; a multiple of 8
//  ADDR_WIDTH       16    byte address width
//  STRB_WIDTH       DATA_WIDTH/8   write strobe width
//  MEM_WORDS        1024  number of words implemented, 1..2**(ADDR_WIDTH-$clog2(STRB_WIDTH))
//  BASE_ADDR        0     byte address of word 0; must be word-aligned
//  PIPELINE_OUTPUT  1     1 = extra output register on the read path (read latency 2); 0 = latency 1
//  ARB_MODE         0     0 = round-robin between read and write; 1 = write always wins
// PORTS
//  clk             in   1           clock, all logic on the rising edge
//  rst_n           in   1           synchronous reset, active-low
//  s_axil_awaddr   in   ADDR_WIDTH  write address
//  s_axil_awprot   in   3           ignored
//  s_axil_awvalid  in   1           write address valid
//  s_axil_awready  out  1           write address ready
//  s_axil_wdata    in   DATA_WIDTH  write data
//  s_axil_wstrb    in   STRB_WIDTH  byte enables
//  s_axil_wvalid   in   1           write data valid
//  s_axil_wready   out  1           write data ready
//  s_axil_bresp    out  2           write response: 2'b00 OKAY, 2'b10 SLVERR
//  s_axil_bvalid   out  1           write response valid
//  s_axil_bready   in   1           write response ready
//  s_axil_araddr   in   ADDR_WIDTH  read address
//  s_axil_arprot   in   3           ignored
//  s_axil_arvalid  in   1           read address valid
//  s_axil_arready  out  1           read address ready
//  s_axil_rdata    out  DATA_WIDTH  read data
//  s_axil_rresp    out  2           read response: 2'b00 OKAY, 2'b10 SLVERR
//  s_axil_rvalid   out  1           read data valid
//  s_axil_rready   in   1           read data ready
// BEHAVIOUR
//  Reset
//  - While rst_n=0: all readys, bvalid and rvalid are 0; bresp, rresp and rdata are 0; the last-grant flag is cleared (read is next in round-robin).
//  - Memory contents are not cleared by reset. They are initialised to 0 at time zero only.
//  - Reset mid-transaction drops every pending response. A write that was accepted before reset has already updated memory.
//  Address decode
//  - idx = (addr - BASE_ADDR) >> $clog2(STRB_WIDTH); the low byte-offset bits are ignored.
//  - The address is in range iff addr >= BASE_ADDR and idx < MEM_WORDS. Compare at ADDR_WIDTH+1 bits so the subtraction cannot wrap.
//  Write path
//  - A write is eligible when awvalid && wvalid && (!bvalid || bready).
//  - When the write is granted, awready and wready pulse together for one cycle, so AW and W are accepted in the same cycle.
//  - In-range write: update the bytes with wstrb=1 and set bresp=OKAY. wstrb=0 is legal and leaves memory unchanged.
//  - Out-of-range write: memory is unchanged and bresp=SLVERR.
//  - bvalid rises in the cycle after accept and holds, with bresp stable, until bready.
//  Read path
//  - A read is eligible when arvalid and the output stage can take a new beat: it is empty, or it drains this cycle (rvalid && rready).
//  - When the read is granted, arready pulses for one cycle.
//  - Latency from accept to rvalid is 1 cycle, or 2 when PIPELINE_OUTPUT=1.
//  - With PIPELINE_OUTPUT=1 the path holds up to 2 beats in flight. arready must never allow a third.
//  - Out-of-range read: rdata=0, rresp=SLVERR, no array access.
//  - rdata and rresp hold stable while rvalid && !rready.
//  - With rready held high, reads are back-to-back at one per cycle.
//  Arbitration (evaluated every cycle)
//  - Only one requester is eligible: it is granted.
//  - Both eligible, ARB_MODE=1: the write is granted.
//  - Both eligible, ARB_MODE=0: the side not granted last time is granted. The last-grant flag updates only on a grant.
//  - Ordering: a granted write is visible to any read granted in a later cycle. No read-during-write in the same cycle.
//  - An ungranted requester keeps its valid asserted; nothing is lost.
//  - The block never asserts a ready before its valid is present; readys are combinational on the eligibility terms.
// TESTING
//  1. Write 0xDEADBEEF, wstrb=0xF, to 0x0010; then read 0x0010 -> bresp=00, then rdata=0xDEADBEEF, rresp=00.
//  2. Write 0x000000AA, wstrb=0x1, over the word from test 1; read it -> 0xDEADBEAA.
//  3. MEM_WORDS=1000, BASE_ADDR=0x1000: write 0x1FA0 (idx 1000) -> bresp=10; read 0x0FFC -> rresp=10, rdata=0; read 0x1F9C -> OKAY.
//  4. AW/W/AR all valid every cycle, ARB_MODE=0 -> grants alternate R,W,R,W; ARB_MODE=1 -> only writes are granted until AW/W drop.
//  5. rready=0 for 5 cycles with PIPELINE_OUTPUT=1 -> at most 2 ARs accepted; rdata stable; release -> data returned in order.
//  6. Drive rst_n=0 for one cycle while bvalid=1 and a read is in flight -> next cycle bvalid=rvalid=0; the written data persists.

Source files
------------

// File: rtl/axil_ram_arb.sv
// AXI4-Lite RAM slave on a single-port array with a base-addressed window
// (SLVERR outside it) and selectable read/write arbitration.
module axil_ram_arb #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          ADDR_WIDTH      = 16,
  parameter int          STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int          MEM_WORDS       = 1024,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int          PIPELINE_OUTPUT = 1,
  parameter int          ARB_MODE        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int OFF = $clog2(STRB_WIDTH);
  localparam int MW_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] WORDS_EXT = (ADDR_WIDTH + 1)'(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One extra bit so an address below the base cannot wrap into the window.
  function automatic logic [ADDR_WIDTH:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] offset;
    offset = {1'b0, addr} - BASE_EXT;
    return offset >> OFF;
  endfunction

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH:0] idx);
    return ({1'b0, addr} >= BASE_EXT) && (idx < WORDS_EXT);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: {DATA_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   wr_idx_s;
  logic [ADDR_WIDTH:0]   rd_idx_s;
  logic                  wr_in_s;
  logic                  rd_in_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  wr_elig_s;
  logic                  rd_elig_s;
  logic                  rd_room_s;
  logic                  grant_w_s;
  logic                  grant_r_s;
  logic                  bvalid_r;
  logic [1:0]            bresp_r;
  logic                  last_rd_r;
  logic                  rvalid_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;
  logic                  unused_s;

  assign unused_s = ^{s_axil_awprot, s_axil_arprot};

  // Address decode, eligibility and the read/write grant decision
  always_comb begin
    wr_idx_s = word_index(s_axil_awaddr);
    rd_idx_s = word_index(s_axil_araddr);
    wr_in_s  = in_window(s_axil_awaddr, wr_idx_s);
    rd_in_s  = in_window(s_axil_araddr, rd_idx_s);
    if (rd_in_s) begin
      rd_word_s = mem[rd_idx_s[MW_W-1:0]];
    end else begin
      rd_word_s = {DATA_WIDTH{1'b0}};
    end
    wr_elig_s = rst_n && s_axil_awvalid && s_axil_wvalid && (!bvalid_r || s_axil_bready);
    rd_elig_s = rst_n && s_axil_arvalid && rd_room_s;
    if (wr_elig_s && rd_elig_s) begin
      grant_w_s = (ARB_MODE == 1) || last_rd_r;
    end else begin
      grant_w_s = wr_elig_s;
    end
    grant_r_s = rd_elig_s && !grant_w_s;
  end

  assign s_axil_awready = grant_w_s;
  assign s_axil_wready  = grant_w_s;
  assign s_axil_arready = grant_r_s;
  assign s_axil_bvalid  = bvalid_r;
  assign s_axil_bresp   = bresp_r;
  assign s_axil_rvalid  = rvalid_r;
  assign s_axil_rdata   = rdata_r;
  assign s_axil_rresp   = rresp_r;

  // Byte-enabled array write; contents are deliberately kept across reset
  always_ff @(posedge clk) begin
    if (grant_w_s && wr_in_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axil_wstrb[b]) begin
          mem[wr_idx_s[MW_W-1:0]][8*b +: 8] <= s_axil_wdata[8*b +: 8];
        end
      end
    end
  end

  // Write response channel and round-robin history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      last_rd_r <= 1'b0;
    end else begin
      if (grant_w_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_in_s ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bready) begin
        bvalid_r <= 1'b0;
      end
      if (grant_w_s) begin
        last_rd_r <= 1'b0;
      end else if (grant_r_s) begin
        last_rd_r <= 1'b1;
      end
    end
  end

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_pipe
      logic                  s1_valid_r;
      logic [DATA_WIDTH-1:0] s1_data_r;
      logic [1:0]            s1_resp_r;
      logic                  move_s;

      // Stage 1 advances whenever the output register is free or draining
      assign move_s    = s1_valid_r && (!rvalid_r || s_axil_rready);
      assign rd_room_s = !(s1_valid_r && rvalid_r && !s_axil_rready);

      // Two-stage read path: array register then output register
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_valid_r <= 1'b0;
          s1_data_r  <= {DATA_WIDTH{1'b0}};
          s1_resp_r  <= 2'b00;
          rvalid_r   <= 1'b0;
          rdata_r    <= {DATA_WIDTH{1'b0}};
          rresp_r    <= 2'b00;
        end else begin
          if (grant_r_s) begin
            s1_valid_r <= 1'b1;
            s1_data_r  <= rd_word_s;
            s1_resp_r  <= rd_in_s ? RESP_OKAY : RESP_SLVERR;
          end else if (move_s) begin
            s1_valid_r <= 1'b0;
          end
          if (move_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= s1_data_r;
            rresp_r  <= s1_resp_r;
          end else if (s_axil_rready) begin
            rvalid_r <= 1'b0;
          end
        end
      end
    end else begin : g_direct
      assign rd_room_s = !rvalid_r || s_axil_rready;

      // Single-register read path
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rvalid_r <= 1'b0;
          rdata_r  <= {DATA_WIDTH{1'b0}};
          rresp_r  <= 2'b00;
        end else begin
          if (grant_r_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_word_s;
            rresp_r  <= rd_in_s ? RESP_OKAY : RESP_SLVERR;
          end else if (s_axil_rready) begin
            rvalid_r <= 1'b0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axil_ram_arb.sv
// Scoreboard bench for axil_ram_arb: a windowed round-robin instance (main)
// and a write-priority instance (wp) that shares its inputs.
module tb_axil_ram_arb;
  localparam int WORDS = 1000;
  localparam logic [15:0] BASE = 16'h1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] awaddr = 16'h0, araddr = 16'h0;
  logic [2:0]  awprot = 3'b000, arprot = 3'b000;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  wstrb = 4'h0;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        wp_awready, wp_wready, wp_bvalid, wp_arready, wp_rvalid;
  logic [1:0]  wp_bresp, wp_rresp;
  logic [31:0] wp_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_mem [WORDS];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [1:0]  last_bresp = 2'b11;
  logic [33:0] last_r = 34'h0;
  logic        log_en = 1'b0;
  logic [1:0]  glog [$];
  int          wp_w = 0, wp_r = 0;

  axil_ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(WORDS), .BASE_ADDR(32'h1000),
                 .PIPELINE_OUTPUT(1), .ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready));

  axil_ram_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_WORDS(1024), .BASE_ADDR(32'h0),
                 .PIPELINE_OUTPUT(0), .ARB_MODE(1)) wp (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(wp_awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wp_wready),
    .s_axil_bresp(wp_bresp), .s_axil_bvalid(wp_bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(wp_arready),
    .s_axil_rdata(wp_rdata), .s_axil_rresp(wp_rresp), .s_axil_rvalid(wp_rvalid), .s_axil_rready(rready));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= BASE) && ((int'(a) - int'(BASE)) / 4 < WORDS);
  endfunction

  // Monitor: handshakes seen at negedge complete at the following posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      bq.delete();
      rq.delete();
    end else begin
      if (awvalid && awready) begin
        if (in_win(awaddr)) begin
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) model_mem[(int'(awaddr) - int'(BASE)) / 4][8*b +: 8] = wdata[8*b +: 8];
          bq.push_back(2'b00);
        end else begin
          bq.push_back(2'b10);
        end
      end
      if (arvalid && arready) begin
        if (in_win(araddr)) rq.push_back({2'b00, model_mem[(int'(araddr) - int'(BASE)) / 4]});
        else rq.push_back({2'b10, 32'h0});
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) check_val("b_queue_len", bq.size(), 1);
        else check_val("bresp", bresp, bq.pop_front());
        last_bresp = bresp;
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check_val("r_queue_len", rq.size(), 1);
        else check_val("rresp_rdata", {rresp, rdata}, rq.pop_front());
        last_r = {rresp, rdata};
      end
      if (log_en) begin
        if (arready) glog.push_back(2'd0);
        else if (awready) glog.push_back(2'd1);
        if (wp_awready) wp_w++;
        if (wp_arready) wp_r++;
      end
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc = 1'b0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (!acc) check_val("write_accept_timeout", acc, 1);
  endtask

  task automatic do_read(input logic [15:0] a);
    bit acc = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin acc = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!acc) check_val("read_accept_timeout", acc, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (bq.size() == 0 && rq.size() == 0) break;
    end
    check_val("drain_pending", bq.size() + rq.size(), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit have;
    logic [33:0] first;
    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;

    // Reset with every valid raised: nothing may be accepted or reported
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    check_val("reset_resp_data", {rdata, rresp, bresp}, 36'h0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b1;

    // Full-word write and read back
    do_write(16'h1010, 32'hDEADBEEF, 4'hF);
    drain();
    check_val("t1_bresp", last_bresp, 2'b00);
    do_read(16'h1010);
    drain();
    check_val("t1_read", last_r, {2'b00, 32'hDEADBEEF});

    // Single-byte strobe, then an all-zero strobe that must not alter memory
    do_write(16'h1010, 32'h000000AA, 4'h1);
    do_read(16'h1010);
    drain();
    check_val("t2_read", last_r, {2'b00, 32'hDEADBEAA});
    do_write(16'h1012, 32'hFFFFFFFF, 4'h0);
    do_read(16'h1010);
    drain();
    check_val("t2_zero_strb", last_r, {2'b00, 32'hDEADBEAA});

    // Window edges
    do_write(16'h1FA0, 32'h01020304, 4'hF);
    drain();
    check_val("t3_wr_above", last_bresp, 2'b10);
    do_read(16'h0FFC);
    drain();
    check_val("t3_rd_below", last_r, {2'b10, 32'h0});
    do_write(16'h1F9C, 32'h12345678, 4'hF);
    drain();
    check_val("t3_wr_last", last_bresp, 2'b00);
    do_read(16'h1F9C);
    drain();
    check_val("t3_rd_last", last_r, {2'b00, 32'h12345678});

    // Contention: round-robin on main, write-priority on wp
    do_write(16'h1020, 32'h00000055, 4'hF);
    drain();
    apply_reset();
    awaddr = 16'h1020; wdata = 32'h11112222; wstrb = 4'hF; araddr = 16'h1020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; log_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; log_en = 1'b0;
    @(negedge clk);
    check_val("t4_wp_read_after_writes_drop", wp_arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain();
    check_val("t4_grant_count", glog.size(), 8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("t4_grant_%0d", i), (i < glog.size()) ? glog[i] : 2'd2, 2'(i % 2));
    check_val("t4_wp_writes", wp_w, 8);
    check_val("t4_wp_reads", wp_r, 0);

    // Output stall with two-deep read pipeline
    for (int k = 0; k < 4; k++) do_write(16'h1100 + 16'(4 * k), 32'hA0 + 32'(k), 4'hF);
    drain();
    rready = 1'b0; acc = 0; have = 1'b0; first = 34'h0;
    araddr = 16'h1100; arvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid) begin
        if (have) check_val("t5_rdata_hold", {rresp, rdata}, first);
        else begin first = {rresp, rdata}; have = 1'b1; end
      end
      if (arready) acc++;
      @(posedge clk); #1;
      araddr = 16'h1100 + 16'(4 * acc);
    end
    arvalid = 1'b0;
    check_val("t5_max_in_flight", acc <= 2, 1'b1);
    check_val("t5_some_accepted", acc >= 1, 1'b1);
    rready = 1'b1;
    drain();
    check_val("t5_last_in_order", last_r, {2'b00, 32'hA0 + 32'(acc - 1)});

    // Reset while a B response is held and a read is in flight
    bready = 1'b0;
    do_write(16'h1200, 32'hCAFEF00D, 4'hF);
    rready = 1'b0;
    do_read(16'h1010);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t6_bvalid_before_reset", bvalid, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("t6_valids_after_reset", {bvalid, rvalid}, 2'b00);
    bready = 1'b1; rready = 1'b1;
    do_read(16'h1200);
    drain();
    check_val("t6_write_persists", last_r, {2'b00, 32'hCAFEF00D});
    do_read(16'h1010);
    drain();
    check_val("t6_old_data", last_r, {2'b00, 32'hDEADBEAA});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
